// File: rtl/tank_pkg.sv
// Shared keycodes, facing directions and motion states for the tank controller.
package tank_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } motion_state_t;

endpackage

// File: rtl/vs_edge_sync.sv
// Synchronises VGA vsync and emits a one-cycle tick on its falling edge.
// Tick appears 3 cycles after the raw vsync fall; sync flops reset high.
module vs_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vs_i,
  output logic tick_o
);

  logic s1_q, s2_q, prev_q, tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= vs_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      tick_q <= prev_q & ~s2_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-frame tank position, facing and rate-limited fire from a HID keycode.
// One update per vsync falling edge; position visible the cycle after frame_tick.
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int TANK_SIZE = 16,
  parameter int STEP      = 2,
  parameter int FIRE_CD   = 30,
  parameter int X_INIT    = 312,
  parameter int Y_INIT    = 232
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic       vga_vs,
  output logic       frame_tick,
  output logic [9:0] tank_x,
  output logic [9:0] tank_y,
  output logic [1:0] tank_dir,
  output logic       moving,
  output logic       fire_pulse
);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - TANK_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - TANK_SIZE);

  logic [7:0]    key_q;
  logic [9:0]    x_q, y_q;
  dir_t          dir_q;
  motion_state_t state_q;
  logic          moving_q;
  logic [4:0]    cd_q;

  logic [10:0]   x_d, y_d, x_sum, y_sum;
  dir_t          dir_d;
  logic          is_dir, moved, fire;

  vs_edge_sync u_vs_sync (
    .clk_i   (clk_clk),
    .rst_n_i (reset_reset_n),
    .vs_i    (vga_vs),
    .tick_o  (frame_tick)
  );

  // Sums are kept 11 bits wide so the clamp compare sees any overflow past 1023.
  always_comb begin
    x_sum  = {1'b0, x_q} + STEP_W;
    y_sum  = {1'b0, y_q} + STEP_W;
    x_d    = {1'b0, x_q};
    y_d    = {1'b0, y_q};
    dir_d  = dir_q;
    is_dir = 1'b1;
    case (key_q)
      KEY_W: begin
        y_d   = ({1'b0, y_q} < STEP_W) ? 11'd0 : {1'b0, y_q} - STEP_W;
        dir_d = DIR_UP;
      end
      KEY_D: begin
        x_d   = (x_sum > X_MAX) ? X_MAX : x_sum;
        dir_d = DIR_RIGHT;
      end
      KEY_S: begin
        y_d   = (y_sum > Y_MAX) ? Y_MAX : y_sum;
        dir_d = DIR_DOWN;
      end
      KEY_A: begin
        x_d   = ({1'b0, x_q} < STEP_W) ? 11'd0 : {1'b0, x_q} - STEP_W;
        dir_d = DIR_LEFT;
      end
      default: is_dir = 1'b0;
    endcase
    moved = (x_d[9:0] != x_q) || (y_d[9:0] != y_q);
    fire  = frame_tick && (key_q == KEY_SPACE) && (cd_q == 5'd0);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      key_q    <= 8'h00;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      dir_q    <= DIR_UP;
      state_q  <= IDLE;
      moving_q <= 1'b0;
      cd_q     <= 5'd0;
    end else begin
      key_q <= keycode;
      if (frame_tick) begin
        x_q   <= x_d[9:0];
        y_q   <= y_d[9:0];
        dir_q <= dir_d;
        if (!is_dir) begin
          state_q  <= IDLE;
          moving_q <= 1'b0;
        end else if (moved) begin
          state_q  <= MOVE;
          moving_q <= 1'b1;
        end else begin
          state_q  <= BLOCKED;
          moving_q <= 1'b0;
        end
        if (fire)
          cd_q <= 5'(FIRE_CD);
        else if (cd_q != 5'd0)
          cd_q <= cd_q - 5'd1;
      end
    end
  end

  assign tank_x     = x_q;
  assign tank_y     = y_q;
  assign tank_dir   = dir_q;
  assign moving     = moving_q;
  assign fire_pulse = fire;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Randomised and directed frames checked against a frame-level behavioural model.
module tb_tank_motion_ctrl;
  import tank_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       vga_vs = 1'b1;
  logic       frame_tick, moving, fire_pulse;
  logic [9:0] tank_x, tank_y;
  logic [1:0] tank_dir;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: plain integers, one update per frame.
  int mx, my, mdir, mst, mcd;

  always #5 clk = ~clk;

  tank_motion_ctrl dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .keycode       (keycode),
    .vga_vs        (vga_vs),
    .frame_tick    (frame_tick),
    .tank_x        (tank_x),
    .tank_y        (tank_y),
    .tank_dir      (tank_dir),
    .moving        (moving),
    .fire_pulse    (fire_pulse)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_state_code(input int s);
    motion_state_t e;
    e = (s == 1) ? MOVE : (s == 2) ? BLOCKED : IDLE;
    return int'(e);
  endfunction

  task automatic model_reset();
    mx = 312; my = 232; mdir = 0; mst = 0; mcd = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_x"}, int'(tank_x), mx);
    chk({tag, "_y"}, int'(tank_y), my);
    chk({tag, "_dir"}, int'(tank_dir), mdir);
    chk({tag, "_moving"}, int'(moving), (mst == 1) ? 1 : 0);
    chk({tag, "_state"}, int'(dut.state_q), exp_state_code(mst));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs("reset");
    chk("reset_tick", int'(frame_tick), 0);
    chk("reset_fire", int'(fire_pulse), 0);
    rst_n = 1'b1;
  endtask

  task automatic frame(input logic [7:0] key, output bit fired);
    int  lat, nx, ny;
    bit  seen, exp_fire;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      keycode = 8'($urandom);
      chk("tick_quiet", int'(frame_tick), 0);
    end
    @(negedge clk);
    keycode = key;
    vga_vs  = 1'b0;

    exp_fire = (key == 8'h2C) && (mcd == 0);
    if (exp_fire) mcd = 30;
    else if (mcd > 0) mcd = mcd - 1;
    nx = mx; ny = my;
    case (key)
      8'h1A: begin ny = (my - 2 < 0) ? 0 : my - 2;       mdir = 0; end
      8'h07: begin nx = (mx + 2 > 624) ? 624 : mx + 2;   mdir = 1; end
      8'h16: begin ny = (my + 2 > 464) ? 464 : my + 2;   mdir = 2; end
      8'h04: begin nx = (mx - 2 < 0) ? 0 : mx - 2;       mdir = 3; end
      default: ;
    endcase
    if (key == 8'h1A || key == 8'h07 || key == 8'h16 || key == 8'h04)
      mst = (nx != mx || ny != my) ? 1 : 2;
    else
      mst = 0;
    mx = nx; my = ny;

    seen = 1'b0; lat = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (frame_tick) seen = 1'b1;
    end
    chk("tick_seen", int'(seen), 1);
    chk("tick_latency", lat, 3);
    chk("fire", int'(fire_pulse), int'(exp_fire));
    fired = fire_pulse;
    @(negedge clk);
    keycode = 8'($urandom);
    chk("tick_width", int'(frame_tick), 0);
    chk("fire_width", int'(fire_pulse), 0);
    check_outputs("frame");
    vga_vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_key(input logic [7:0] key, input int n);
    bit f;
    for (int i = 0; i < n; i++) frame(key, f);
  endtask

  initial begin
    logic [7:0] keys [6];
    bit f;
    int pulses, first_p, last_p, hold_x;
    keys = '{8'h1A, 8'h07, 8'h16, 8'h04, 8'h2C, 8'h00};

    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("por");
    chk("por_fire", int'(fire_pulse), 0);
    chk("por_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_tick_after_reset", int'(frame_tick), 0);

    run_key(8'h07, 10);
    chk("basic_x", int'(tank_x), 332);
    chk("basic_dir", int'(tank_dir), 1);
    chk("basic_moving", int'(moving), 1);

    run_key(8'h04, 170);
    chk("left_wall_x", int'(tank_x), 0);
    chk("left_wall_blocked", int'(dut.state_q), int'(BLOCKED));
    run_key(8'h1A, 130);
    chk("top_wall_y", int'(tank_y), 0);
    run_key(8'h16, 250);
    chk("bottom_wall_y", int'(tank_y), 464);
    chk("bottom_blocked_moving", int'(moving), 0);
    run_key(8'h07, 320);
    chk("right_wall_x", int'(tank_x), 624);

    pulses = 0; first_p = -1; last_p = -1;
    for (int i = 0; i < 70; i++) begin
      frame(8'h2C, f);
      if (f) begin
        pulses++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    chk("fire_count", pulses, 3);
    chk("fire_first", first_p, 0);
    chk("fire_last", last_p, 62);
    chk("fire_no_motion", int'(moving), 0);

    // Reset mid-cooldown must let the next SPACE frame fire immediately.
    do_reset();
    frame(8'h2C, f);
    frame(8'h2C, f);
    do_reset();
    frame(8'h2C, f);
    chk("fire_after_reset", int'(f), 1);

    hold_x = int'(tank_x);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      keycode = keys[i % 4];
      chk("vs_high_no_tick", int'(frame_tick), 0);
    end
    chk("vs_high_hold_x", int'(tank_x), hold_x);
    @(negedge clk);
    keycode = 8'h00;

    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [7:0] k;
      sel = $urandom_range(0, 7);
      k = (sel < 6) ? keys[sel] : 8'($urandom);
      frame(k, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
